// File: rtl/srt_div_pkg.sv
// srt_div_pkg: shared constants and state encoding for the SRT mantissa divider
package srt_div_pkg;
    localparam int MANT_W    = 24;
    localparam int REM_W     = MANT_W + 2;
    localparam int ITER_CNT  = MANT_W;
    localparam int CNT_W     = $clog2(ITER_CNT + 1);
    localparam int DIGIT_MIN = -3;
    localparam int DIGIT_MAX = 2;
    typedef enum logic [1:0] {IDLE, ITER, CORRECT, DONE} srt_state_t;
endpackage

// File: rtl/srt_digit_mult.sv
// srt_digit_mult: signed digit times divisor by shift/add of D and 2D with negation
module srt_digit_mult
    import srt_div_pkg::*;
(
    input  logic [MANT_W-1:0] digit,
    input  logic [REM_W-1:0]  divisor,
    output logic [REM_W-1:0]  prod
);
    logic [2:0]       q3;
    logic [1:0]       mag;
    logic             neg;
    logic [REM_W-1:0] m;
    // out-of-range digits saturate to the legal range before the 3-bit encoding
    assign q3 = $signed(digit) > $signed(MANT_W'(DIGIT_MAX)) ? 3'(DIGIT_MAX) :
                $signed(digit) < $signed(MANT_W'(DIGIT_MIN)) ? 3'(DIGIT_MIN) : digit[2:0];
    assign neg  = q3[2];
    assign mag  = neg ? ~q3[1:0] + 2'd1 : q3[1:0];
    assign m    = (mag[0] ? divisor : '0) + (mag[1] ? {divisor[REM_W-2:0], 1'b0} : '0);
    assign prod = neg ? -m : m;
endmodule

// File: rtl/srt_div_iter.sv
// srt_div_iter: iterative SRT mantissa divider; digits come from an external selector.
// Define SRT_DIV_STICKY_EN to add the sticky (final remainder non-zero) output.
module srt_div_iter
    import srt_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [REM_W-1:0]  sel_rem,
    output logic [REM_W-1:0]  sel_div,
    input  logic [MANT_W-1:0] sel_digit,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [MANT_W-1:0] quotient,
    output logic [REM_W-1:0]  remainder,
    output logic              div_by_zero
`ifdef SRT_DIV_STICKY_EN
    ,output logic             sticky
`endif
);
    srt_state_t        state;
    logic [REM_W-1:0]  r, d, prod, w, r_fix;
    logic [MANT_W-1:0] q;
    logic [CNT_W-1:0]  cnt;
    logic              dbz, last, dz;

    srt_digit_mult u_mult (.digit(sel_digit), .divisor(d), .prod(prod));

    assign w     = r - prod;
    assign last  = cnt == CNT_W'(ITER_CNT - 1);
    assign r_fix = r[REM_W-1] ? r + d : r;
    assign dz    = divisor == '0;

    assign start_ready = state == IDLE;
    assign done_valid  = state == DONE;
    assign sel_rem     = r;
    assign sel_div     = d;
    assign quotient    = q;
    assign remainder   = r;
    assign div_by_zero = dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            d     <= '0;
            q     <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
`ifdef SRT_DIV_STICKY_EN
            sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    r     <= {2'b00, dividend};
                    d     <= {2'b00, divisor};
                    cnt   <= '0;
                    dbz   <= dz;
                    q     <= dz ? '1 : '0;
                    state <= dz ? DONE : ITER;
`ifdef SRT_DIV_STICKY_EN
                    sticky <= dz && dividend != '0;
`endif
                end
                ITER: begin
                    q     <= {q[MANT_W-2:0], 1'b0} + sel_digit;
                    r     <= last ? w : {w[REM_W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    state <= last ? CORRECT : ITER;
                end
                CORRECT: begin
                    r     <= r_fix;
                    q     <= r[REM_W-1] ? q - MANT_W'(1) : q;
                    state <= DONE;
`ifdef SRT_DIV_STICKY_EN
                    sticky <= r_fix != '0;
`endif
                end
                DONE: if (done_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_srt_div_iter.sv
// tb_srt_div_iter: directed checks of the SRT divider with a stub digit selector
module tb_srt_div_iter;
    logic        clk = 0;
    logic        rst = 1;
    logic        start_valid = 0;
    logic        start_ready;
    logic [23:0] dividend = 0;
    logic [23:0] divisor = 0;
    logic [25:0] sel_rem, sel_div;
    logic [23:0] sel_digit;
    logic        done_valid;
    logic        done_ready = 0;
    logic [23:0] quotient;
    logic [25:0] remainder;
    logic        div_by_zero;
`ifdef SRT_DIV_STICKY_EN
    logic        sticky;
`endif
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mode = 0;
    int it;
    logic [23:0] rest;

    srt_div_iter dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .dividend(dividend), .divisor(divisor), .sel_rem(sel_rem), .sel_div(sel_div),
        .sel_digit(sel_digit), .done_valid(done_valid), .done_ready(done_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
`ifdef SRT_DIV_STICKY_EN
        , .sticky(sticky)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: restoring selector; 1: -1 on last digit; 2: +1 on last digit; 3: +2,-3,+2 then restoring
    always_comb begin
        it = cyc - acc_cyc;
        rest = ($signed(sel_rem) >= $signed(sel_div)) ? 24'd1 : 24'd0;
        sel_digit = rest;
        if (mode == 1 && it == 23) sel_digit = 24'hFFFFFF;
        if (mode == 2 && it == 23) sel_digit = 24'd1;
        if (mode == 3) sel_digit = it == 0 ? 24'd2 : it == 1 ? 24'hFFFFFD : it == 2 ? 24'd2 : rest;
    end

    task automatic start_op(input logic [23:0] a, input logic [23:0] b);
        int n = 0;
        while (!start_ready && n < 100) begin @(posedge clk); #1; n++; end
        start_valid = 1; dividend = a; divisor = b;
        @(posedge clk); #1;
        acc_cyc = cyc;
        start_valid = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!done_valid) begin errors++; $display("FAIL done_timeout: done_valid=%0b required 1", done_valid); end
    endtask

    task automatic release_done;
        done_ready = 1;
        @(posedge clk); #1;
        done_ready = 0;
    endtask

    task automatic check_result(input string name, input logic [23:0] eq, input logic [25:0] er, input logic sk);
        checks++;
        if (quotient !== eq) begin errors++; $display("FAIL %s_quotient: got %h required %h", name, quotient, eq); end
        checks++;
        if (remainder !== er) begin errors++; $display("FAIL %s_remainder: got %h required %h", name, remainder, er); end
        checks++;
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL %s_dbz: got %b required 0", name, div_by_zero); end
`ifdef SRT_DIV_STICKY_EN
        checks++;
        if (sticky !== sk) begin errors++; $display("FAIL %s_sticky: got %b required %b", name, sticky, sk); end
`else
        if (sk === 1'bx) $display("note: sticky not built");
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({start_ready, done_valid, div_by_zero} !== 3'b100) begin
            errors++; $display("FAIL %s_flags: got sr/dv/dbz=%b required 100", name, {start_ready, done_valid, div_by_zero});
        end
        checks++;
        if (quotient !== 24'h0 || remainder !== 26'h0) begin
            errors++; $display("FAIL %s_result: got q=%h r=%h required 0/0", name, quotient, remainder);
        end
        checks++;
        if (sel_rem !== 26'h0 || sel_div !== 26'h0) begin
            errors++; $display("FAIL %s_sel: got rem=%h div=%h required 0/0", name, sel_rem, sel_div);
        end
`ifdef SRT_DIV_STICKY_EN
        checks++;
        if (sticky !== 1'b0) begin errors++; $display("FAIL %s_sticky: got %b required 0", name, sticky); end
`endif
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;
    endtask

    task automatic test_divide;
        int lat;
        mode = 0;
        start_op(24'h800000, 24'h800000);
        wait_done(lat);
        checks++;
        if (lat !== 26) begin errors++; $display("FAIL latency: got %0d required 26", lat); end
        check_result("one", 24'h800000, 26'h0, 1'b0);
        release_done;
        start_op(24'hC00000, 24'h800000);
        wait_done(lat);
        check_result("three_halves", 24'hC00000, 26'h0, 1'b0);
        release_done;
        start_op(24'h800000, 24'hC00000);
        wait_done(lat);
        check_result("two_thirds", 24'h555555, 26'h0400000, 1'b1);
        release_done;
    endtask

    task automatic test_div_by_zero;
        mode = 0;
        start_op(24'hABCDEF, 24'h0);
        checks++;
        if (done_valid !== 1'b1) begin errors++; $display("FAIL dbz_latency: done_valid=%b required 1", done_valid); end
        checks++;
        if (quotient !== 24'hFFFFFF || remainder !== 26'h0ABCDEF || div_by_zero !== 1'b1) begin
            errors++; $display("FAIL dbz_result: got q=%h r=%h dbz=%b required FFFFFF/0ABCDEF/1", quotient, remainder, div_by_zero);
        end
`ifdef SRT_DIV_STICKY_EN
        checks++;
        if (sticky !== 1'b1) begin errors++; $display("FAIL dbz_sticky: got %b required 1", sticky); end
`endif
        release_done;
    endtask

    task automatic test_back_to_back;
        int lat;
        mode = 0;
        start_op(24'hC00000, 24'h800000);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            start_valid = i[0]; dividend = 24'hABCDEF; divisor = 24'h0;
            @(posedge clk); #1;
            checks++;
            if (done_valid !== 1'b1 || start_ready !== 1'b0 || quotient !== 24'hC00000 || remainder !== 26'h0 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got dv=%b sr=%b q=%h r=%h dbz=%b required 1/0/C00000/0/0",
                         i, done_valid, start_ready, quotient, remainder, div_by_zero);
            end
        end
        done_ready = 1; start_valid = 1; dividend = 24'h800000; divisor = 24'hC00000;
        @(posedge clk); #1;
        done_ready = 0;
        checks++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
            errors++; $display("FAIL release: got sr=%b dv=%b required 1/0", start_ready, done_valid);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        start_valid = 0;
        checks++;
        if (start_ready !== 1'b0) begin errors++; $display("FAIL next_accept: start_ready=%b required 0", start_ready); end
        wait_done(lat);
        checks++;
        if (lat !== 26) begin errors++; $display("FAIL next_latency: got %0d required 26", lat); end
        check_result("next_op", 24'h555555, 26'h0400000, 1'b1);
        release_done;
    endtask

    task automatic test_reset_mid;
        mode = 0;
        start_op(24'h800000, 24'hC00000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_correction;
        int lat;
        mode = 2;
        start_op(24'h800000, 24'h800000);
        wait_done(lat);
        check_result("over_last", 24'h800000, 26'h0, 1'b0);
        release_done;
        mode = 1;
        start_op(24'h800000, 24'h800000);
        wait_done(lat);
        check_result("minus_last", 24'h7FFFFF, 26'h0800000, 1'b1);
        release_done;
        mode = 3;
        start_op(24'h800000, 24'h800000);
        wait_done(lat);
        check_result("wide_digits", 24'h800000, 26'h0, 1'b0);
        release_done;
        mode = 0;
    endtask

    initial begin
        test_reset;
        test_divide;
        test_div_by_zero;
        test_back_to_back;
        test_reset_mid;
        test_correction;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
